// File: rtl/seq_divider_if.sv
// Request/response bundle between the operand-select path and seq_divider.
// The master drives a division request; the slave returns busy/done/result.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             want_rem;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, dividend, divisor, is_signed, want_rem,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, dividend, divisor, is_signed, want_rem,
        output busy, done, result, zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU (WIDTH edges per op).
// Optional macro DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] count_q,      count_d;
    logic [WIDTH-1:0] remAcc_q,     remAcc_d;
    logic [WIDTH-1:0] quo_q,        quo_d;
    logic [WIDTH-1:0] divisorMag_q, divisorMag_d;
    logic [WIDTH-1:0] result_q,     result_d;
    logic             wantRem_q,    wantRem_d;
    logic             negQuot_q,    negQuot_d;
    logic             negRem_q,     negRem_d;

    logic [WIDTH-1:0] dividendMag;
    logic [WIDTH-1:0] divisorMagIn;
    logic             divZero;
    logic             overflow;
    logic             earlyOut;
    logic [WIDTH:0]   shiftedFull;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic [WIDTH-1:0] finalQuo;
    logic [WIDTH-1:0] finalRem;

    assign dividendMag  = (bus.is_signed && bus.dividend[WIDTH-1]) ? (~bus.dividend + ONE) : bus.dividend;
    assign divisorMagIn = (bus.is_signed && bus.divisor[WIDTH-1])  ? (~bus.divisor + ONE)  : bus.divisor;
    assign divZero      = (bus.divisor == '0);
    assign overflow     = bus.is_signed && (bus.dividend == MOST_NEG) && (bus.divisor == '1);

`ifdef DIV_EARLY_OUT_EN
    assign earlyOut = !divZero && (dividendMag < divisorMagIn);
`else
    assign earlyOut = 1'b0;
`endif

    // remAcc_q stays below 2^(WIDTH-1) until the last step, so keeping its MSB
    // in the trial subtraction is equivalent to dropping it.
    assign shiftedFull = {remAcc_q, quo_q[WIDTH-1]};
    assign trial       = shiftedFull - {1'b0, divisorMag_q};
    assign stepRem     = trial[WIDTH] ? shiftedFull[WIDTH-1:0] : trial[WIDTH-1:0];
    assign stepQuo     = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    assign finalQuo    = negQuot_q ? (~stepQuo + ONE) : stepQuo;
    assign finalRem    = negRem_q  ? (~stepRem + ONE) : stepRem;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        remAcc_d     = remAcc_q;
        quo_d        = quo_q;
        divisorMag_d = divisorMag_q;
        result_d     = result_q;
        wantRem_d    = wantRem_q;
        negQuot_d    = negQuot_q;
        negRem_d     = negRem_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    wantRem_d    = bus.want_rem;
                    negQuot_d    = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    negRem_d     = bus.is_signed & bus.dividend[WIDTH-1];
                    divisorMag_d = divisorMagIn;
                    remAcc_d     = '0;
                    quo_d        = dividendMag;
                    count_d      = CNT_INIT;
                    if (divZero) begin
                        result_d = bus.want_rem ? bus.dividend : '1;
                        state_d  = S_DONE;
                    end else if (overflow) begin
                        result_d = bus.want_rem ? '0 : bus.dividend;
                        state_d  = S_DONE;
                    end else if (earlyOut) begin
                        result_d = bus.want_rem ? bus.dividend : '0;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end

            S_CALC: begin
                remAcc_d = stepRem;
                quo_d    = stepQuo;
                count_d  = count_q - CNT_ONE;
                if (count_q == '0) begin
                    result_d = wantRem_q ? finalRem : finalQuo;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            remAcc_q     <= '0;
            quo_q        <= '0;
            divisorMag_q <= '0;
            result_q     <= '0;
            wantRem_q    <= 1'b0;
            negQuot_q    <= 1'b0;
            negRem_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            remAcc_q     <= remAcc_d;
            quo_q        <= quo_d;
            divisorMag_q <= divisorMag_d;
            result_q     <= result_d;
            wantRem_q    <= wantRem_d;
            negQuot_q    <= negQuot_d;
            negRem_q     <= negRem_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.zero   = (result_q == '0);
endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [WIDTH-1:0] prevResult = '0;

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the RISC-V rules for /0 and overflow.
    function automatic logic [WIDTH-1:0] refResult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                   input bit sgn, input bit rem);
        longint sa, sb, q, r;
        if (b == 0) return rem ? a : '1;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return rem ? r[WIDTH-1:0] : q[WIDTH-1:0];
    endfunction

    function automatic longint magOf(input logic [WIDTH-1:0] v, input bit sgn);
        longint x;
        x = sgn ? longint'($signed(v)) : longint'({32'b0, v});
        return (x < 0) ? -x : x;
    endfunction

    function automatic bit isShortcut(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit sgn);
        bit s;
        s = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
        s = s || (b != 0 && magOf(a, sgn) < magOf(b, sgn));
`endif
        return s;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input bit sgn, input bit rem, input bit midStart);
        logic [WIDTH-1:0] expected;
        int expLat;
        int edges;
        expected = refResult(a, b, sgn, rem);
        expLat   = isShortcut(a, b, sgn) ? 0 : WIDTH;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = sgn;
        bus.want_rem  = rem;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        bus.is_signed = 1'($urandom);
        bus.want_rem  = 1'($urandom);
        checkOutput("busyAfterStart", 64'(bus.busy), 64'd1);
        if (expLat != 0) checkOutput("resultHeld", 64'(bus.result), 64'(prevResult));
        edges = 0;
        while (!bus.done && edges < 3 * WIDTH) begin
            if (midStart && edges == 5) bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            edges++;
        end
        checkOutput("latency", 64'(edges), 64'(expLat));
        checkOutput("result", 64'(bus.result), 64'(expected));
        checkOutput("zero", 64'(bus.zero), 64'(expected == 0));
        @(posedge clk);
        #1;
        checkOutput("donePulse", 64'(bus.done), 64'd0);
        checkOutput("idleAfterDone", 64'(bus.busy), 64'd0);
        prevResult = expected;
    endtask

    initial begin
        int edges;
        int doneCount;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_signed = 1'b0;
        bus.want_rem  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetBusy", 64'(bus.busy), 64'd0);
        checkOutput("resetDone", 64'(bus.done), 64'd0);
        checkOutput("resetResult", 64'(bus.result), 64'd0);
        checkOutput("resetZero", 64'(bus.zero), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h8000_0005, 32'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'd3, 32'd10, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'd3, 32'd10, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);

        // A start pulse in the middle of CALC must not launch a second operation.
        applyStimulus(32'd1000, 32'd9, 1'b0, 1'b0, 1'b1);
        doneCount = 0;
        repeat (WIDTH + 8) begin
            @(posedge clk);
            #1;
            if (bus.done) doneCount++;
        end
        checkOutput("noExtraDone", 64'(doneCount), 64'd0);

        // Asynchronous reset ten cycles into CALC aborts the operation.
        bus.dividend  = 32'd12345;
        bus.divisor   = 32'd17;
        bus.is_signed = 1'b0;
        bus.want_rem  = 1'b0;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstBusy", 64'(bus.busy), 64'd0);
        checkOutput("asyncRstDone", 64'(bus.done), 64'd0);
        checkOutput("asyncRstResult", 64'(bus.result), 64'd0);
        checkOutput("asyncRstZero", 64'(bus.zero), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prevResult = '0;
        doneCount = 0;
        repeat (WIDTH + 8) begin
            @(posedge clk);
            #1;
            if (bus.done) doneCount++;
        end
        checkOutput("abortedNoDone", 64'(doneCount), 64'd0);
        applyStimulus(32'd12345, 32'd17, 1'b0, 1'b1, 1'b0);

        // Start held high continuously: one result every WIDTH+2 cycles.
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        bus.is_signed = 1'b0;
        bus.want_rem  = 1'b0;
        bus.start     = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.done && edges < 3 * WIDTH);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.done && edges < 3 * WIDTH);
        bus.start = 1'b0;
        checkOutput("backToBackPeriod", 64'(edges), 64'(WIDTH + 2));
        checkOutput("backToBackResult", 64'(bus.result), 64'd14);
        edges = 0;
        while (bus.busy && edges < 3 * WIDTH) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("backToBackIdle", 64'(bus.busy), 64'd0);
        prevResult = 32'd14;

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 50);
                2:       a = -$urandom_range(1, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                3:       b = -$urandom_range(1, 20);
                default: b = $urandom;
            endcase
            applyStimulus(a, b, 1'($urandom), 1'($urandom), (i % 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider that implements RISC-V DIV/DIVU/REM/REMU.
- Sits beside the combinational ALU, fed by the same operand-select path: word1 goes to dividend, word2 goes to divisor.
- Its result feeds the writeback result mux alongside the ALU output.
- The control unit stalls the PC while busy=1, so divide no longer sits in the single-cycle critical path.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a division. Sampled only in IDLE.
- dividend  input  WIDTH  numerator, sampled with start.
- divisor  input  WIDTH  denominator, sampled with start.
- is_signed  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU. Sampled with start.
- want_rem  input  1  1 = result is remainder, 0 = result is quotient. Sampled with start.
- busy  output  1  high in CALC and DONE. Used as the PC stall.
- done  output  1  one-cycle pulse: result valid.
- result  output  WIDTH  quotient or remainder. Registered.
- zero  output  1  (result == 0). Combinational from the result register.

Behaviour:
- Reset: clk is single clock; rst_n is asynchronous active-low. Reset forces state=IDLE, busy=0, done=0, result=0, zero=1, and clears all internal registers.
- Reset mid-operation aborts the operation; no done is ever produced for it.
- FSM states: IDLE, CALC, DONE. Outputs are Moore: busy=(state!=IDLE), done=(state==DONE).
- IDLE + start=1 at edge E0:
  - Latch is_signed and want_rem.
  - Latch operand magnitudes |dividend| and |divisor| when is_signed=1, else the raw values.
  - Latch neg_q = is_signed & (dividend[MSB] ^ divisor[MSB]) and neg_r = is_signed & dividend[MSB].
  - Set rem_acc=0, quo=|dividend|, count=WIDTH-1.
- Special cases at E0 (bypass CALC, go directly to DONE; done is high the cycle after start):
  - divisor==0: quotient = all ones; remainder = dividend (raw).
  - is_signed & dividend==100..0 & divisor==all ones (overflow): quotient = dividend; remainder = 0.
- CALC, one step per edge:
  - trial = {rem_acc[WIDTH-2:0], quo[MSB]} − divisor_mag, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem_acc = trial, shift quo left inserting 1.
  - Otherwise: rem_acc = shifted value, shift quo left inserting 0.
  - Decrement count.
  - On the edge where count==0: apply the sign fix (quotient negated if neg_q, remainder negated if neg_r), load result with the selected value, go to DONE.
  - Total: WIDTH CALC edges. done is high in the cycle after edge E0+WIDTH.
- DONE lasts one cycle, then returns to IDLE at the next edge regardless of start. A start during DONE is ignored.
- start asserted in CALC or DONE is ignored; the requester must hold or re-assert it in IDLE.
- result holds its value after DONE until the next accepted operation writes it. It is not cleared on start.
- Back-to-back: start high continuously gives one operation every WIDTH+2 cycles.
- Operand inputs may change freely after E0; only the latched copies are used.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: at E0, if the unsigned magnitudes satisfy |dividend| < |divisor| (divisor≠0), go directly to DONE with quotient=0 and remainder=dividend (raw, sign preserved).
- Not defined: these cases take the full WIDTH-cycle CALC path. Final values are identical either way; only latency differs.

Test Plan:
- Unsigned 100/7, want_rem=0 then 1 → result 14, then 2. done pulses exactly 33 cycles after each start edge; busy high 33 cycles; zero=0.
- Signed −7/2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Signed 7/−2 → quotient −3, remainder 1.
- Divide by zero: DIVU 0x1234/0 → 0xFFFFFFFF. REM 0x80000005/0 → 0x80000005. done the cycle after start.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0 (zero=1). done after 1 cycle.
- Reset and ignored starts:
  - rst_n low at CALC cycle 10 → busy, done, result all 0 immediately (asynchronous). A new start after release completes correctly.
  - start pulsed mid-CALC → no second done.
- With DIV_EARLY_OUT_EN: DIVU 3/10 → quotient 0, remainder 3, done after 1 cycle. Without the macro: same values after 33 cycles.
